// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
// mips_dbg_pkg : shared debug-unit constants, MEM access sizes, dump FSM states
// Revision     : 1.0
// ============================================================================
package mips_dbg_pkg;

  typedef logic [2:0] bhw_t;

  localparam bhw_t BHW_BYTE  = 3'b000;
  localparam bhw_t BHW_HALF  = 3'b001;
  localparam bhw_t BHW_WORD  = 3'b011;
  localparam bhw_t BHW_BYTEU = 3'b100;
  localparam bhw_t BHW_HALFU = 3'b101;
  localparam bhw_t BHW_WORDU = 3'b111;

  localparam int NB_DUMP_STATE = 3;

  typedef enum logic [NB_DUMP_STATE-1:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } dump_state_e;

  localparam int DUMP_NB_ADDR = 9;

  function automatic int dump_words(input int nb_addr);
    return 2 ** (nb_addr - 2);
  endfunction

  localparam int DUMP_WORDS = dump_words(DUMP_NB_ADDR);

endpackage
`default_nettype wire

// File: rtl/mem_dump_reader_if.sv
`default_nettype none
// ============================================================================
// mem_dump_reader_if : MEM read port plus UART transmitter byte handshake
// Revision           : 1.0
// ============================================================================
interface mem_dump_reader_if
  import mips_dbg_pkg::*;
#(
  parameter int NB_WIDTH = 32,
  parameter int NB_DATA  = 8
);
  logic [NB_WIDTH-1:0] mem_addr;
  logic                mem_read;
  bhw_t                bhw;
  logic [NB_WIDTH-1:0] read_data;
  logic [NB_DATA-1:0]  tx_data;
  logic                tx_start;
  logic                tx_done;

  modport master (
    output mem_addr, mem_read, bhw, tx_data, tx_start,
    input  read_data, tx_done
  );

  modport slave (
    input  mem_addr, mem_read, bhw, tx_data, tx_start,
    output read_data, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/mem_dump_reader_serializer.sv
`default_nettype none
// ============================================================================
// word_byte_serializer : holds one word and presents it MSB-first, NB_DATA at a time
// Revision             : 1.0
// ============================================================================
module word_byte_serializer
  import mips_dbg_pkg::*;
#(
  parameter int NB_WIDTH = 32,
  parameter int NB_DATA  = 8
) (
  input  wire logic                i_clk,
  input  wire logic                i_reset,
  input  wire logic                i_load,
  input  wire logic [NB_WIDTH-1:0] i_word,
  input  wire logic                i_shift,
  output logic      [NB_DATA-1:0]  o_byte,
  output logic                     o_last
);
  localparam int c_CHUNKS = NB_WIDTH / NB_DATA;
  localparam int c_CW     = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;

  logic [NB_WIDTH-1:0] r_shift;
  logic [c_CW-1:0]     r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= r_shift << NB_DATA;
      r_cnt   <= r_cnt + c_CW'(1);
    end
  end

  // The top byte is a register output, so it stays put while the transmitter works.
  assign o_byte = r_shift[NB_WIDTH-1 -: NB_DATA];
  assign o_last = (r_cnt == c_CW'(c_CHUNKS - 1));

endmodule
`default_nettype wire

// File: rtl/mem_dump_reader.sv
`default_nettype none
// ============================================================================
// mem_dump_reader : walks data memory word by word and streams it to uart_tx
// Revision        : 1.0
// ============================================================================
module mem_dump_reader
  import mips_dbg_pkg::*;
#(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9,
  parameter int NB_DATA  = 8
) (
  input  wire logic          i_clk,
  input  wire logic          i_reset,
  input  wire logic          i_start,
  input  wire logic          i_abort,
  mem_dump_reader_if.master  bus,
  output logic               o_busy,
  output logic               o_done
);
  localparam int NB_IDX = NB_ADDR - 2;
  localparam logic [NB_IDX-1:0] c_LAST_WORD = NB_IDX'(dump_words(NB_ADDR) - 1);

  dump_state_e       r_state;
  logic [NB_IDX-1:0] r_word_idx;
  logic              r_mem_read;
  logic              r_tx_start;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_shift;
  logic              w_last_byte;
  logic [NB_DATA-1:0] w_byte;

  assign w_load  = (r_state == ST_CAPTURE) && !i_abort;
  assign w_shift = (r_state == ST_WAIT_TX) && bus.tx_done && !w_last_byte && !i_abort;

  word_byte_serializer #(
    .NB_WIDTH (NB_WIDTH),
    .NB_DATA  (NB_DATA)
  ) u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_word  (bus.read_data),
    .i_shift (w_shift),
    .o_byte  (w_byte),
    .o_last  (w_last_byte)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_mem_read <= 1'b0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      if (i_abort && (r_state != ST_IDLE)) begin
        r_state    <= ST_IDLE;
        r_mem_read <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start && !i_abort) begin
              r_word_idx <= '0;
              r_mem_read <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= ST_REQ;
            end
          end
          ST_REQ:     r_state <= ST_CAPTURE;
          ST_CAPTURE: begin
            r_mem_read <= 1'b0;
            r_tx_start <= 1'b1;
            r_state    <= ST_SEND;
          end
          // A tx_done seen while the start pulse is out belongs to an older byte.
          ST_SEND:    r_state <= ST_WAIT_TX;
          ST_WAIT_TX: begin
            if (bus.tx_done) begin
              if (!w_last_byte) begin
                r_tx_start <= 1'b1;
                r_state    <= ST_SEND;
              end else if (r_word_idx != c_LAST_WORD) begin
                r_word_idx <= r_word_idx + NB_IDX'(1);
                r_mem_read <= 1'b1;
                r_state    <= ST_REQ;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_mem_read <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mem_addr = NB_WIDTH'({r_word_idx, 2'b00});
  assign bus.mem_read = r_mem_read;
  assign bus.bhw      = BHW_WORD;
  assign bus.tx_data  = w_byte;
  assign bus.tx_start = r_tx_start;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_reader.sv
`default_nettype none
// ============================================================================
// tb_mem_dump_reader : table-driven and randomized bench for mem_dump_reader
// Revision           : 1.0
// ============================================================================
module tb_mem_dump_reader;
  import mips_dbg_pkg::*;

  localparam int NB_WIDTH = 32;
  localparam int NB_ADDR  = 9;
  localparam int NB_DATA  = 8;
  localparam int N_WORDS  = 2 ** (NB_ADDR - 2);
  localparam int N_BYTES  = 2 ** NB_ADDR;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;

  mem_dump_reader_if #(.NB_WIDTH(NB_WIDTH), .NB_DATA(NB_DATA)) bus ();

  mem_dump_reader #(
    .NB_WIDTH (NB_WIDTH),
    .NB_ADDR  (NB_ADDR),
    .NB_DATA  (NB_DATA)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start),
    .i_abort (abort),
    .bus     (bus),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory, observed stream and transmitter model state
  logic [31:0] mem [N_WORDS];
  logic [7:0]  rx_q[$];
  logic [31:0] addr_q[$];
  int          done_cnt;
  int          start_cnt;
  int          real_done_cnt;
  int          order_err;
  int          stable_err;
  int          tx_delay;
  bit          tx_glitch;
  bit          tx_pending;
  int          tx_cnt;
  bit          waiting;
  logic [7:0]  held;
  logic        prev_read;

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory responder, transmitter model and protocol monitor, all on the falling edge
  initial begin
    bus.read_data = '0;
    bus.tx_done   = 1'b0;
    tx_pending = 0; tx_cnt = 0; waiting = 0; held = '0; prev_read = 1'b0;
    done_cnt = 0; start_cnt = 0; real_done_cnt = 0; order_err = 0; stable_err = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_read && !prev_read) addr_q.push_back(bus.mem_addr);
      prev_read = bus.mem_read;
      bus.read_data = bus.mem_read ? mem[bus.mem_addr[NB_ADDR-1:2]] : 32'h0;
      if (done) done_cnt++;
      if (waiting && !bus.tx_start && (bus.tx_data !== held)) stable_err++;
      bus.tx_done = 1'b0;
      if (bus.tx_start) begin
        if (start_cnt != real_done_cnt) order_err++;
        start_cnt++;
        rx_q.push_back(bus.tx_data);
        held       = bus.tx_data;
        waiting    = 1;
        tx_pending = 1;
        tx_cnt     = (tx_delay == 0) ? int'($urandom_range(1, 6)) - 1 : tx_delay - 1;
        if (tx_glitch) bus.tx_done = 1'b1;
      end else if (tx_pending) begin
        if (tx_cnt == 0) begin
          bus.tx_done = 1'b1;
          tx_pending  = 0;
          waiting     = 0;
          real_done_cnt++;
        end else begin
          tx_cnt--;
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          pattern;    // 0: {k,k,k,k}, 1: random + endianness words, 2: random
    int          delay;      // transmitter wait in cycles, 0 selects random 1..6
    bit          glitch;     // extra tx_done pulse during the start cycle
    bit          restart;    // second i_start at byte 7
    int          exp_bytes;
    int          exp_dones;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic fill_mem(input int pattern);
    for (int k = 0; k < N_WORDS; k++)
      mem[k] = (pattern == 0) ? 32'(k) * 32'h0101_0101 : $urandom;
    if (pattern == 1) begin
      mem[4] = 32'h1234_5678;
      mem[0] = 32'h0000_0001;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.mem_addr, bus.mem_read, bus.bhw, bus.tx_data, bus.tx_start, busy, done},
                {32'h0, 1'b0, 3'b011, 8'h00, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_dump(input string tag, input bit restart_at7, input int exp_bytes,
                          input int exp_dones, input logic [31:0] exp_last);
    bit pulsed;
    int cyc;
    int nerr;
    logic [7:0] exp_b;
    pulsed = 0;
    rx_q.delete(); addr_q.delete(); done_cnt = 0;
    pulse_start();
    check({tag, "_start"}, {busy, bus.mem_read, bus.mem_addr}, {1'b1, 1'b1, 32'h0});
    cyc = 0;
    while (done_cnt == 0 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (restart_at7 && !pulsed && rx_q.size() == 7) begin
        start  = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_dones"}, done_cnt, exp_dones);
    check({tag, "_bytes"}, rx_q.size(), exp_bytes);
    nerr = 0;
    for (int n = 0; n < N_BYTES; n++) begin
      exp_b = 8'(mem[n / 4] >> (8 * (3 - (n % 4))));
      if (n >= rx_q.size() || rx_q[n] !== exp_b) nerr++;
    end
    check({tag, "_stream_errors"}, nerr, 0);
    nerr = 0;
    for (int k = 0; k < N_WORDS; k++)
      if (k >= addr_q.size() || addr_q[k] !== 32'(4 * k)) nerr++;
    check({tag, "_addr_errors"}, {32'(addr_q.size()), 32'(nerr)}, {32'(N_WORDS), 32'h0});
    if (addr_q.size() > 0)
      check({tag, "_last_addr"}, addr_q[addr_q.size()-1], exp_last);
  endtask

  initial begin
    int nerr;
    int snap;
    int cyc;
    logic last_read;
    n_checks = 0; n_fail = 0;
    start = 1'b0; abort = 1'b0; rst = 1'b1;
    tx_delay = 3; tx_glitch = 0;

    vecs[0] = '{pattern: 0, delay: 3,  glitch: 0, restart: 0, exp_bytes: 512, exp_dones: 1, exp_last_addr: 32'h1FC};
    vecs[1] = '{pattern: 1, delay: 1,  glitch: 0, restart: 0, exp_bytes: 512, exp_dones: 1, exp_last_addr: 32'h1FC};
    vecs[2] = '{pattern: 2, delay: 10, glitch: 0, restart: 0, exp_bytes: 512, exp_dones: 1, exp_last_addr: 32'h1FC};
    vecs[3] = '{pattern: 2, delay: 1,  glitch: 1, restart: 0, exp_bytes: 512, exp_dones: 1, exp_last_addr: 32'h1FC};
    vecs[4] = '{pattern: 2, delay: 0,  glitch: 0, restart: 1, exp_bytes: 512, exp_dones: 1, exp_last_addr: 32'h1FC};

    fill_mem(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill_mem(vecs[v].pattern);
      tx_delay  = vecs[v].delay;
      tx_glitch = vecs[v].glitch;
      run_dump($sformatf("vec%0d", v), vecs[v].restart, vecs[v].exp_bytes,
               vecs[v].exp_dones, vecs[v].exp_last_addr);
      if (v == 0) begin
        nerr = 0;
        for (int n = 0; n < N_BYTES; n++)
          if (n >= rx_q.size() || rx_q[n] !== 8'(n >> 2)) nerr++;
        check("basic_byte_is_n_div_4", nerr, 0);
      end
      if (v == 1 && rx_q.size() >= 20) begin
        check("endian_0x10", {rx_q[16], rx_q[17], rx_q[18], rx_q[19]}, 32'h1234_5678);
        check("endian_0x00", {rx_q[0], rx_q[1], rx_q[2], rx_q[3]}, 32'h0000_0001);
      end
    end
    tx_glitch = 0;

    // Start and abort together in IDLE: abort wins
    addr_q.delete();
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", {busy, bus.mem_read}, 2'b00);
    repeat (5) @(negedge clk);
    check("start_abort_idle_no_read", addr_q.size(), 0);

    // Abort at word 5
    fill_mem(2);
    tx_delay = 2;
    rx_q.delete(); addr_q.delete(); done_cnt = 0;
    pulse_start();
    cyc = 0;
    while (rx_q.size() < 21 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_word5", rx_q.size(), 21);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_outputs", {busy, bus.mem_read, bus.tx_start, done}, 4'b0000);
    snap = start_cnt;
    repeat (30) @(negedge clk);
    check("abort_no_more_tx", start_cnt, snap);
    check("abort_no_done", done_cnt, 0);
    tx_delay = 0;
    run_dump("after_abort", 0, 512, 1, 32'h1FC);

    // Reset while in CAPTURE of word 2
    fill_mem(2);
    tx_delay = 1;
    rx_q.delete(); addr_q.delete(); done_cnt = 0;
    pulse_start();
    cyc = 0;
    last_read = 1'b0;
    while (!(rx_q.size() >= 8 && bus.mem_read && last_read) && cyc < 2000) begin
      last_read = bus.mem_read;
      @(negedge clk);
      cyc++;
    end
    check("reset_reached_capture", {bus.mem_read, bus.mem_addr}, {1'b1, 32'h8});
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_capture");
    rst = 1'b0;
    snap = addr_q.size();
    repeat (20) @(negedge clk);
    check("reset_stays_idle", {busy, 32'(addr_q.size())}, {1'b0, 32'(snap)});
    tx_delay = 3;
    run_dump("after_reset", 0, 512, 1, 32'h1FC);

    check("tx_start_before_done", order_err, 0);
    check("tx_data_stability", stable_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Initiator-side debug block that walks the whole data memory of the MEM stage and streams its contents out as bytes.
- On a start pulse it issues sequential word reads (LW, BHW=3'b011) on the MEM read port and serializes each word MSB-first.
- Each byte goes to the UART transmitter through a start/done handshake.
- Sits in the debug unit, between the MEM data-memory read port (muxed in while the pipeline is halted) and uart_tx.

Parameters:
- NB_WIDTH, 32, data/address bus width of the MEM port.
- NB_ADDR, 9, byte-address width of data memory (2^NB_ADDR bytes, 2^(NB_ADDR-2) words).
- NB_DATA, 8, byte width sent to the transmitter.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins a dump when idle.
- i_abort  in  1  synchronous abort; returns to IDLE without o_done.
- o_mem_addr  out  NB_WIDTH  byte address to MEM, always word aligned ({idx,2'b00}, zero-extended).
- o_mem_read  out  1  read strobe to MEM.
- o_BHW  out  3  access size to MEM, constant 3'b011 (word).
- i_read_data  in  NB_WIDTH  MEM read data, valid in the cycle after o_mem_read.
- o_tx_data  out  NB_DATA  byte to transmitter.
- o_tx_start  out  1  one-cycle pulse: transmitter latches o_tx_data.
- i_tx_done  in  1  one-cycle pulse from the transmitter: byte finished.
- o_busy  out  1  high from the cycle after an accepted start until the cycle after DONE.
- o_done  out  1  one-cycle pulse when the last byte's i_tx_done is received.

Behaviour:
- Reset values: o_mem_addr=0, o_mem_read=0, o_BHW=3'b011, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0. Internally word_idx=0, byte_cnt=0, shift register=0, state=IDLE.
- Reset has priority over every input, including mid-dump; the next cycle is IDLE.
- State IDLE: on i_start, word_idx<=0 and go to REQ. Otherwise stay.
- State REQ: o_mem_read=1, o_mem_addr={word_idx,2'b00}, go to CAPTURE.
- State CAPTURE: o_mem_read stays 1 and o_mem_addr is held. Latch i_read_data into the shift register, byte_cnt<=0, go to SEND.
- State SEND: o_tx_start=1 for exactly one cycle, with o_tx_data=shift[31:24]. Go to WAIT_TX. An i_tx_done arriving in this cycle is ignored.
- State WAIT_TX: o_tx_data is held stable. On i_tx_done:
  - byte_cnt<3: shift<<=8, byte_cnt++, go to SEND.
  - byte_cnt==3 and word_idx<last word: word_idx++, go to REQ.
  - byte_cnt==3 and word_idx==last word (2^(NB_ADDR-2)-1): go to DONE.
- State DONE: o_done=1 for one cycle, then IDLE.
- i_start while not IDLE is ignored; it never restarts a dump.
- i_abort in any non-IDLE state: next state IDLE, o_mem_read=0, o_tx_start=0, no o_done. A byte already in flight is not recalled.
- If i_abort and i_start arrive in the same IDLE cycle, i_abort wins and no dump starts.
- Word index wrap: none. The index stops at the last word; the address never exceeds (2^NB_ADDR)-4 (0x1FC for the default).
- Per-word latency: 2 cycles (REQ, CAPTURE) plus 4 x (1 + transmitter wait) cycles.
- Stream length: 2^NB_ADDR bytes, 512 for the default. Words are emitted in ascending address order, big-endian within each word.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - BHW constants: BHW_BYTE=3'b000, BHW_HALF=3'b001, BHW_WORD=3'b011, BHW_BYTEU=3'b100, BHW_HALFU=3'b101, BHW_WORDU=3'b111.
  - State encoding localparams for this FSM.
  - DUMP_WORDS = 2^(NB_ADDR-2).
- One natural sub-module, word_byte_serializer: loads a word, then shifts out NB_DATA-bit chunks MSB-first under the tx_start/tx_done handshake. mem_dump_reader owns address sequencing and the top-level FSM.

Test Plan:
- Basic dump: memory model preloaded with word[k]={k,k,k,k} bytes. Transmitter model returns i_tx_done 3 cycles after o_tx_start. Pulse i_start -> 512 bytes received; byte n equals n>>2; o_mem_addr runs 0x000,0x004,...,0x1FC; one o_done pulse; o_busy low afterwards.
- Endianness: word at 0x10 = 0x12345678 -> stream bytes 16..19 are 0x12,0x34,0x56,0x78. Word at 0x000 = 0x00000001 -> bytes 0..3 are 00,00,00,01.
- Handshake timing: i_tx_done delayed 1, 10 and 0 cycles (a done pulse asserted during SEND) -> o_tx_start is never re-asserted before a valid i_tx_done; o_tx_data is stable throughout WAIT_TX; a done during SEND is ignored.
- Start while busy: second i_start pulse at byte 7 -> dump continues uninterrupted, still 512 bytes total, a single o_done.
- Abort mid-dump: i_abort at word 5 -> IDLE next cycle, o_busy=0, no o_done, no further o_tx_start. A fresh i_start then restarts from address 0x000.
- Reset mid-operation: i_reset asserted in CAPTURE -> all outputs at reset values the next cycle, o_mem_read=0. The dump restarts from 0 only on a new i_start.
